// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for RV32 M-extension DIV/DIVU/REM/REMU.
// One trial subtraction per cycle on an unsigned core. Signed operands are converted to
// magnitudes when the request is accepted, and the sign correction is applied when the
// result is registered. Divide-by-zero and signed overflow skip the loop and take one cycle.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      request valid; accepted when i_valid & o_ready & ~i_kill
//   o_ready      high only while idle
//   i_op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_dividend   rs1, sampled only on the accepting edge
//   i_divisor    rs2, sampled only on the accepting edge
//   i_kill       abort: any state returns to idle, and the result register is left unchanged
//   o_valid      one-cycle result pulse
//   o_result     quotient or remainder, held until the next result is produced
module seq_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_kill,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Iteration datapath
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quo_nxt;

  // Accept-side decode
  logic              op_signed;
  logic              dvd_neg;
  logic              dvs_neg;

  always_comb begin
    // A remainder below the divisor, shifted left by one bit, fits in XLEN+1 bits. The
    // difference then lies in (-divisor, divisor), so bit XLEN is a valid sign bit.
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh + ~{1'b0, dvs_q} + (XLEN+1)'(1);
    rem_nxt = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};

    op_signed = ~i_op[0];
    dvd_neg   = op_signed & i_dividend[XLEN-1];
    dvs_neg   = op_signed & i_divisor[XLEN-1];
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    valid_d   = 1'b0;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid && !i_kill) begin
          if (i_divisor == '0) begin
            result_d = i_op[1] ? i_dividend : '1;
            valid_d  = 1'b1;
            state_d  = StDone;
          end else if (op_signed && (i_dividend == MinVal) && (i_divisor == '1)) begin
            result_d = i_op[1] ? '0 : MinVal;
            valid_d  = 1'b1;
            state_d  = StDone;
          end else begin
            rem_d     = '0;
            quo_d     = dvd_neg ? (~i_dividend + XLEN'(1)) : i_dividend;
            dvs_d     = dvs_neg ? (~i_divisor + XLEN'(1)) : i_divisor;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            is_rem_d  = i_op[1];
            cnt_d     = CntW'(XLEN - 1);
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          if (is_rem_q) begin
            result_d = neg_rem_q ? (~rem_nxt + XLEN'(1)) : rem_nxt;
          end else begin
            result_d = neg_quo_q ? (~quo_nxt + XLEN'(1)) : quo_nxt;
          end
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Kill overrides everything: no pulse for the aborted op and the old result stays.
    if (i_kill) begin
      state_d  = StIdle;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  assign o_ready  = (state_q == StIdle);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule
